// File: rtl/csa_addsub_pipe_if.sv
// Operand/result handshake bundle for csa_addsub_pipe.
// The master drives operands and out_ready; the slave (the adder) drives results.
interface csa_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             overflow;
    logic             ovf_sticky;
    logic             clr_sticky;

    modport master (
        output in_valid, a, b, ci, op, out_ready, clr_sticky,
        input  in_ready, out_valid, s, co, overflow, ovf_sticky
    );

    modport slave (
        input  in_valid, a, b, ci, op, out_ready, clr_sticky,
        output in_ready, out_valid, s, co, overflow, ovf_sticky
    );
endinterface

// File: rtl/csa_addsub_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshakes,
// carry-out, signed overflow and a sticky overflow flag.
module csa_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input logic              clock,
    input logic              reset,
    csa_addsub_pipe_if.slave bus
);
    localparam int         NBLK   = WIDTH / BLOCK;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;

    function automatic logic [BLOCK:0] blk_add(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             cin
    );
        logic [BLOCK-1:0] sum;
        logic             c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, sum};
    endfunction

    logic [WIDTH-1:0] w_b_cond;
    logic             w_c0;
    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_sum;
    logic [NBLK:0]    w_carry;
    logic             w_ovf;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_c0;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;
    logic             r_ovf_sticky;

    // Operand conditioning: subtraction is a + ~b + 1; code 11 falls back to ADD.
    always_comb begin
        w_b_cond = bus.b;
        w_c0     = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_b_cond = bus.b;
                w_c0     = 1'b0;
            end
            OP_SUB: begin
                w_b_cond = ~bus.b;
                w_c0     = 1'b1;
            end
            OP_ADC: begin
                w_b_cond = bus.b;
                w_c0     = bus.ci;
            end
            default: begin
                w_b_cond = bus.b;
                w_c0     = 1'b0;
            end
        endcase
    end

    assign w_s2_load  = !r_out_valid || bus.out_ready;
    assign w_in_ready = !reset && (!r_s1_valid || w_s2_load);
    assign w_out_xfer = r_out_valid && bus.out_ready;

    // Stage 1 register: conditioned operands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c0    <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            r_s1_a     <= bus.a;
            r_s1_b     <= w_b_cond;
            r_s1_c0    <= w_c0;
        end
    end

    assign w_carry[0] = r_s1_c0;

    // Block 0 ripples from c0; upper blocks precompute both carry-ins and select.
    for (genvar gk = 0; gk < NBLK; gk++) begin : g_blk
        localparam int LO = gk * BLOCK;
        if (gk == 0) begin : g_ripple
            logic [BLOCK:0] w_res;
            assign w_res                 = blk_add(r_s1_a[LO +: BLOCK], r_s1_b[LO +: BLOCK], w_carry[0]);
            assign w_sum[LO +: BLOCK]    = w_res[BLOCK-1:0];
            assign w_carry[1]            = w_res[BLOCK];
        end else begin : g_select
            logic [BLOCK:0] w_res0;
            logic [BLOCK:0] w_res1;
            assign w_res0                = blk_add(r_s1_a[LO +: BLOCK], r_s1_b[LO +: BLOCK], 1'b0);
            assign w_res1                = blk_add(r_s1_a[LO +: BLOCK], r_s1_b[LO +: BLOCK], 1'b1);
            assign w_sum[LO +: BLOCK]    = w_carry[gk] ? w_res1[BLOCK-1:0] : w_res0[BLOCK-1:0];
            assign w_carry[gk+1]         = w_carry[gk] ? w_res1[BLOCK] : w_res0[BLOCK];
        end
    end

    assign w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);

    // Stage 2 register: result held stable while downstream stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            r_s         <= w_sum;
            r_co        <= w_carry[NBLK];
            r_ovf       <= w_ovf;
        end
    end

    // Sticky overflow: a delivered overflowing result beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_out_xfer && r_ovf) begin
            r_ovf_sticky <= 1'b1;
        end else if (bus.clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.s          = r_s;
    assign bus.co         = r_co;
    assign bus.overflow   = r_ovf;
    assign bus.ovf_sticky = r_ovf_sticky;
endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Scoreboard bench for csa_addsub_pipe: directed 32/8 checks plus random sweeps
// at 16/4, 32/8 and 64/16 against an arithmetic reference model.
module tb_csa_addsub_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Result as {overflow, co, s zero-extended to 64 bits}, from plain integer arithmetic.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                              input logic ci, input logic [1:0] op);
        logic [63:0]        mask, a, b, s;
        logic [64:0]        full;
        logic               co, ovf;
        logic signed [66:0] sa, sb, sv, lim;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = $signed({3'b000, a});
        if (a[w-1]) sa = sa - (67'sd1 <<< w);
        sb   = $signed({3'b000, b});
        if (b[w-1]) sb = sb - (67'sd1 <<< w);
        lim  = 67'sd1 <<< (w - 1);
        case (op)
            2'b01: begin
                full = {1'b0, a} - {1'b0, b};
                co   = (a >= b);
                sv   = sa - sb;
            end
            2'b10: begin
                full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
                co   = full[w];
                sv   = sa + sb + $signed({66'd0, ci});
            end
            default: begin
                full = {1'b0, a} + {1'b0, b};
                co   = full[w];
                sv   = sa + sb;
            end
        endcase
        s   = full[63:0] & mask;
        ovf = (sv >= lim) || (sv < -lim);
        return {ovf, co, s};
    endfunction

    function automatic logic [63:0] rnd_op(input int w);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return (64'd1 << (w - 1)) - 64'd1;
            3:       return 64'd1 << (w - 1);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- directed instance, 32/8 ----------------
    logic rst_d;
    logic [65:0] d_q[$];
    int bp_idx;
    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    logic        bp_ci[4];
    logic [1:0]  bp_op[4];

    csa_addsub_pipe_if #(.WIDTH(32)) d_if();
    csa_addsub_pipe #(.WIDTH(32), .BLOCK(8)) u_dut_d (
        .clock (clk),
        .reset (rst_d),
        .bus   (d_if.slave)
    );

    initial begin : mon_d
        logic [65:0] cur, held;
        bit stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            cur = {d_if.overflow, d_if.co, 32'd0, d_if.s};
            if (!rst_d && d_if.out_valid) begin
                if (stalled) chk("dir_hold", cur, held);
                if (d_if.out_ready) begin
                    stalled = 1'b0;
                    if (d_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dir_extra: got result %h, required none", cur);
                    end else begin
                        chk("dir_result", cur, d_q.pop_front());
                    end
                end else begin
                    held    = cur;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic d_send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic [1:0] op,
                          input logic [31:0] es, input logic eco, input logic eovf);
        int n;
        d_if.in_valid = 1'b1;
        d_if.a        = a;
        d_if.b        = b;
        d_if.ci       = ci;
        d_if.op       = op;
        n = 0;
        @(negedge clk);
        while (!d_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (d_if.in_ready) begin
            d_q.push_back({eovf, eco, 32'd0, es});
        end else begin
            total++;
            bad++;
            $display("FAIL d_send_timeout: in_ready=%0b, required 1", d_if.in_ready);
        end
        @(posedge clk);
        #1;
        d_if.in_valid = 1'b0;
    endtask

    task automatic bp_step(output bit acc);
        if (bp_idx < 4) begin
            d_if.in_valid = 1'b1;
            d_if.a        = bp_a[bp_idx];
            d_if.b        = bp_b[bp_idx];
            d_if.ci       = bp_ci[bp_idx];
            d_if.op       = bp_op[bp_idx];
        end else begin
            d_if.in_valid = 1'b0;
        end
        @(negedge clk);
        acc = d_if.in_valid && d_if.in_ready;
        if (acc) begin
            d_q.push_back(ref_model(32, {32'd0, d_if.a}, {32'd0, d_if.b}, d_if.ci, d_if.op));
            bp_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- random sweeps ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W  = (g == 0) ? 16 : (g == 1) ? 32 : 64;
        localparam int BK = (g == 0) ? 4  : (g == 1) ? 8  : 16;
        logic rst_s;
        logic done_s = 1'b0;
        logic [65:0] q[$];

        csa_addsub_pipe_if #(.WIDTH(W)) s_if();
        csa_addsub_pipe #(.WIDTH(W), .BLOCK(BK)) u_dut (
            .clock (clk),
            .reset (rst_s),
            .bus   (s_if.slave)
        );

        initial begin : mon
            logic [65:0] cur, held;
            logic [63:0] sx;
            bit stalled;
            stalled = 1'b0;
            forever begin
                @(negedge clk);
                sx          = '0;
                sx[W-1:0]   = s_if.s;
                cur         = {s_if.overflow, s_if.co, sx};
                if (!rst_s && s_if.out_valid) begin
                    if (stalled) chk("sweep_hold", cur, held);
                    if (s_if.out_ready) begin
                        stalled = 1'b0;
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sweep_extra w=%0d: got result %h, required none", W, cur);
                        end else begin
                            chk($sformatf("sweep_result_w%0d", W), cur, q.pop_front());
                        end
                    end else begin
                        held    = cur;
                        stalled = 1'b1;
                    end
                end else begin
                    stalled = 1'b0;
                end
            end
        end

        initial begin : drv
            int n;
            bit took;
            logic [63:0] ra, rb, xa, xb;
            rst_s             = 1'b1;
            s_if.in_valid     = 1'b0;
            s_if.a            = '0;
            s_if.b            = '0;
            s_if.ci           = 1'b0;
            s_if.op           = 2'b00;
            s_if.out_ready    = 1'b0;
            s_if.clr_sticky   = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_s = 1'b0;
            n     = 0;
            took  = 1'b0;
            while (n < 10000) begin
                @(posedge clk);
                #1;
                s_if.out_ready  = 1'($urandom_range(0, 1));
                s_if.clr_sticky = ($urandom_range(0, 15) == 0);
                if (!s_if.in_valid || took) begin
                    took          = 1'b0;
                    s_if.in_valid = ($urandom_range(0, 3) != 0);
                    ra            = rnd_op(W);
                    rb            = rnd_op(W);
                    s_if.a        = ra[W-1:0];
                    s_if.b        = rb[W-1:0];
                    s_if.ci       = 1'($urandom_range(0, 1));
                    s_if.op       = 2'($urandom_range(0, 3));
                end
                @(negedge clk);
                if (s_if.in_valid && s_if.in_ready) begin
                    xa        = '0;
                    xb        = '0;
                    xa[W-1:0] = s_if.a;
                    xb[W-1:0] = s_if.b;
                    q.push_back(ref_model(W, xa, xb, s_if.ci, s_if.op));
                    n++;
                    took = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            s_if.in_valid   = 1'b0;
            s_if.out_ready  = 1'b1;
            s_if.clr_sticky = 1'b0;
            for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
            chk($sformatf("sweep_drain_w%0d", W), 66'(q.size()), 66'd0);
            done_s = 1'b1;
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin : main
        bit acc;
        rst_d           = 1'b1;
        d_if.in_valid   = 1'b0;
        d_if.a          = 32'd0;
        d_if.b          = 32'd0;
        d_if.ci         = 1'b0;
        d_if.op         = 2'b00;
        d_if.out_ready  = 1'b0;
        d_if.clr_sticky = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_a[i]  = $urandom;
            bp_b[i]  = $urandom;
            bp_ci[i] = 1'($urandom_range(0, 1));
            bp_op[i] = 2'($urandom_range(0, 3));
        end
        #2;
        chk("reset_outputs", {29'd0, d_if.in_ready, d_if.out_valid, d_if.co, d_if.overflow, d_if.ovf_sticky, d_if.s},
            66'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_d = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 66'(d_if.in_ready), 66'd1);
        repeat (3) @(negedge clk);
        chk("idle_out_valid", 66'(d_if.out_valid), 66'd0);

        @(posedge clk);
        #1;
        d_if.out_ready = 1'b1;
        d_send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2'b00, 32'h8000_0000, 1'b0, 1'b1);
        chk("latency_not_yet", 66'(d_if.out_valid), 66'd0);
        @(posedge clk);
        #1;
        chk("latency_valid", 66'(d_if.out_valid), 66'd1);
        d_send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0);
        d_send(32'h0000_0005, 32'h0000_0007, 1'b0, 2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0);
        d_send(32'h8000_0000, 32'h0000_0001, 1'b0, 2'b01, 32'h7FFF_FFFF, 1'b1, 1'b1);
        d_send(32'h0000_00FF, 32'h0000_0000, 1'b1, 2'b10, 32'h0000_0100, 1'b0, 1'b0);
        d_send(32'h0000_0001, 32'h0000_0002, 1'b1, 2'b11, 32'h0000_0003, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("directed_drain", 66'(d_q.size()), 66'd0);
        chk("sticky_set", 66'(d_if.ovf_sticky), 66'd1);

        d_if.clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        d_if.clr_sticky = 1'b0;
        chk("sticky_clear", 66'(d_if.ovf_sticky), 66'd0);

        d_if.out_ready = 1'b0;
        d_send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 2'b00, 32'hFFFF_FFFE, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("stalled_valid", 66'(d_if.out_valid), 66'd1);
        d_if.out_ready  = 1'b1;
        d_if.clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        chk("sticky_set_wins", 66'(d_if.ovf_sticky), 66'd1);
        @(posedge clk);
        #1;
        chk("sticky_clear_next", 66'(d_if.ovf_sticky), 66'd0);
        d_if.clr_sticky = 1'b0;

        d_if.out_ready = 1'b0;
        bp_idx = 0;
        for (int c = 0; c < 6; c++) bp_step(acc);
        chk("bp_accepted", 66'(bp_idx), 66'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 66'(d_if.in_ready), 66'd0);
        @(posedge clk);
        #1;
        d_if.out_ready = 1'b1;
        bp_step(acc);
        chk("bp_resume_accept", 66'(acc), 66'd1);
        for (int c = 0; c < 10 && bp_idx < 4; c++) bp_step(acc);
        d_if.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drain", 66'(d_q.size()), 66'd0);

        d_if.out_ready = 1'b0;
        d_send(32'h0000_1111, 32'h0000_2222, 1'b0, 2'b00, 32'h0000_3333, 1'b0, 1'b0);
        d_send(32'h0000_4444, 32'h0000_0004, 1'b0, 2'b01, 32'h0000_4440, 1'b1, 1'b0);
        #2;
        rst_d = 1'b1;
        #1;
        chk("reset_mid_out_valid", 66'(d_if.out_valid), 66'd0);
        chk("reset_mid_in_ready", 66'(d_if.in_ready), 66'd0);
        d_q.delete();
        @(posedge clk);
        #1;
        rst_d          = 1'b0;
        d_if.out_ready = 1'b1;
        d_send(32'h1234_5678, 32'h1111_1111, 1'b0, 2'b00, 32'h2345_6789, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("reset_mid_drain", 66'(d_q.size()), 66'd0);

        for (int i = 0; i < 60000 && !(g_sweep[0].done_s && g_sweep[1].done_s && g_sweep[2].done_s); i++)
            @(posedge clk);
        if (!(g_sweep[0].done_s && g_sweep[1].done_s && g_sweep[2].done_s)) begin
            total++;
            bad++;
            $display("FAIL sweep_timeout: done=%0b%0b%0b, required 111",
                     g_sweep[2].done_s, g_sweep[1].done_s, g_sweep[0].done_s);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csa_addsub_pipe.md
# csa_addsub_pipe

Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshakes, carry-out, signed overflow and a sticky overflow flag. It generalises the fixed 32-bit, 8-bit-block carry-select adder in three ways: operand width and block size are parameters, three operation modes are supported, and a registered, back-pressurable pipeline replaces the purely combinational path. It sits between the ALU operand muxes and the writeback/status logic.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of BLOCK.
- BLOCK, 8, carry-select block size in bits; must be ≥2.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; used only in ADC mode.
- op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 reserved (treated as ADD).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum or difference.
- co  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow of this result.
- ovf_sticky  output  1  set once any overflowing result is delivered.
- clr_sticky  input  1  synchronous clear of ovf_sticky.

## Operation
- Operand conditioning happens in stage 1:
  - ADD: b' = b, c0 = 0.
  - SUB: b' = ~b, c0 = 1.
  - ADC: b' = b, c0 = ci.
  - Reserved code 11 behaves exactly as ADD.
- Stage 1 register: captures a, b', c0. The conditioning logic itself is combinational before the register.
- Stage 2 datapath (combinational from stage-1 registers):
  - Block 0 (bits BLOCK-1:0) is a ripple adder using c0.
  - Every higher block computes two sums in parallel, one with carry-in 0 and one with carry-in 1.
  - Each block's sum and carry are selected by the carry of the block below.
  - co is the selected carry out of the top block.
  - overflow = (a[W-1] == b'[W-1]) && (s[W-1] != a[W-1]).
- Stage 2 register: captures s, co and overflow.
- Arithmetic is modulo 2^WIDTH. co has no signed meaning, and overflow has no unsigned meaning. In SUB, co = 1 means no borrow.
- Handshake rules:
  - A beat transfers on in_valid && in_ready. A result transfers on out_valid && out_ready.
  - s2_load = !out_valid || out_ready.
  - in_ready = !reset && (!s1_valid || s2_load). This is combinational and depends on out_ready.
  - On s2_load, stage 2 takes the stage-1 contents and out_valid <= s1_valid.
  - On in_ready, stage 1 takes the inputs and s1_valid <= in_valid.
  - While out_valid && !out_ready, s, co and overflow hold stable. The upstream beat stalls in stage 1.
  - No beat is ever dropped or duplicated.
- Sticky overflow flag:
  - ovf_sticky sets on a result transfer whose overflow = 1.
  - clr_sticky clears it.
  - If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset (asynchronous, immediate):
  - s1_valid, out_valid, s, co, overflow and ovf_sticky are 0.
  - in_ready is 0 while reset is high and 1 in the first cycle after release.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+1. The result is visible during cycle N+1 to N+2.
- Throughput is one beat per cycle when out_ready stays 1.
- Two-entry capacity, stage 1 plus stage 2. With out_ready held 0, exactly two beats are accepted and then in_ready drops to 0.
- When out_ready rises with both stages full, the same cycle both delivers the result and lets in_ready = 1. The stages shift with no bubble.
- If reset asserts mid-stream, all in-flight beats are discarded. No partial result is ever presented.
- Combinational critical path: log-free select chain of WIDTH/BLOCK mux levels plus one BLOCK-bit ripple, confined to stage 2.

## Test plan
- Reset and idle: reset pulse → all outputs 0, then in_ready = 1 after release, out_valid stays 0 with in_valid = 0.
- ADD with WIDTH = 32:
  - 0x7FFFFFFF + 0x00000001 → s = 0x80000000, co = 0, overflow = 1, ovf_sticky = 1 after the transfer.
  - 0xFFFFFFFF + 1 → s = 0, co = 1, overflow = 0.
- SUB and ADC with WIDTH = 32:
  - SUB 5 − 7 → s = 0xFFFFFFFE, co = 0.
  - SUB 0x80000000 − 1 → s = 0x7FFFFFFF, overflow = 1.
  - ADC 0x000000FF + 0 with ci = 1 → s = 0x00000100. This exercises cross-block carry selection.
- Back-pressure:
  - Stream 4 beats with out_ready = 0 → only 2 are accepted and in_ready = 0.
  - Raise out_ready → results arrive in order, each held stable while stalled, with no loss or duplication.
- Sticky priority:
  - Assert clr_sticky in the same cycle as an overflowing transfer → ovf_sticky = 1.
  - clr_sticky alone next cycle → 0.
- Parameter sweep: WIDTH/BLOCK = 16/4, 32/8, 64/16 with 10,000 random beats and random out_ready each → every result matches the reference model a + b' + c0 for s, co and overflow.
- Reset mid-stream: assert reset with two beats in flight → out_valid drops immediately, and the next accepted beat is the first one delivered.
